// File: rtl/alu_adder_arbiter_pkg.sv
// ============================================================================
// Module : alu_arb_pkg
// Brief  : Shared FSM encoding and default sizes for the adder arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_arb_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_adder_arbiter_if.sv
// ============================================================================
// Module : alu_arb_if
// Brief  : Request/response bundle between requesters and the adder arbiter.
//          Carries rsp_ovf only when ALU_ARB_OVF_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_cin;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_cout;
`ifdef ALU_ARB_OVF_EN
    logic                     rsp_ovf;
`endif

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
`ifdef ALU_ARB_OVF_EN
        , input rsp_ovf
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
`ifdef ALU_ARB_OVF_EN
        , output rsp_ovf
`endif
    );
endinterface

`default_nettype wire

// File: rtl/alu_adder_arbiter_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first request at or after ptr,
//          wrapping to the lowest request when none lies above ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_sel;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (i >= int'(ptr));
        end
        w_sel = ((req & w_mask) != '0) ? (req & w_mask) : req;

        // Scan high to low so the lowest set bit of w_sel wins.
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ripplemod.sv
// ============================================================================
// Module : ripplemod
// Brief  : Plain ripple-carry adder, {cout,sum} = a + b + cin.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ripplemod #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[WIDTH];

endmodule

`default_nettype wire

// File: rtl/alu_adder_arbiter.sv
// ============================================================================
// Module : alu_adder_arbiter
// Brief  : Round-robin sharing of one external adder among NUM_REQ requesters.
//          Optional signed-overflow flag enabled by ALU_ARB_OVF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_adder_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int WIDTH         = DEF_WIDTH,
    parameter int ID_W          = $clog2(NUM_REQ),
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_arb_if.slave         bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             busy
);

    localparam int CNT_W = 4;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic               add_cin_q, add_cin_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
    logic               rsp_cout_q, rsp_cout_d;
`ifdef ALU_ARB_OVF_EN
    logic               rsp_ovf_q, rsp_ovf_d;
`endif

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
`ifdef ALU_ARB_OVF_EN
        rsp_ovf_d   = rsp_ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid != '0) begin
                    add_a_d   = bus.req_a[int'(w_grant_idx)*WIDTH +: WIDTH];
                    add_b_d   = bus.req_b[int'(w_grant_idx)*WIDTH +: WIDTH];
                    add_cin_d = bus.req_cin[w_grant_idx];
                    rsp_id_d  = w_grant_idx;
                    cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q == '0) begin
                    rsp_sum_d   = add_sum;
                    rsp_cout_d  = add_cout;
`ifdef ALU_ARB_OVF_EN
                    rsp_ovf_d   = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                                  (add_sum[WIDTH-1] != add_a_q[WIDTH-1]);
`endif
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0
                                                                   : rsp_id_q + ID_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
`ifdef ALU_ARB_OVF_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
`ifdef ALU_ARB_OVF_EN
            rsp_ovf_q   <= rsp_ovf_d;
`endif
        end
    end

    // Grant is an accept strobe, so it must vanish the moment reset asserts.
    assign bus.req_ready = (state_q == ST_IDLE && !rst) ? w_grant : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
`ifdef ALU_ARB_OVF_EN
    assign bus.rsp_ovf   = rsp_ovf_q;
`endif
    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_adder_arbiter.sv
// ============================================================================
// Module : tb_alu_adder_arbiter
// Brief  : Directed plus randomized check of alu_adder_arbiter with ripplemod.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_adder_arbiter;

    localparam int N      = 4;
    localparam int W      = 8;
    localparam int IDW    = $clog2(N);
    localparam int SETTLE = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout, busy;

    alu_arb_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IDW)) bus ();

    alu_adder_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .ID_W(IDW), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
    );

    ripplemod #(.WIDTH(W)) u_adder (
        .a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum), .cout(add_cout)
    );

    always #5 clk = ~clk;

    // Requester-side model: what each requester is presenting, plus pointer.
    logic [W-1:0] ma [N];
    logic [W-1:0] mb [N];
    logic         mc [N];
    logic [N-1:0] mv;
    int           m_ptr;
    int           total = 0;
    int           bad   = 0;
    int           g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.req_valid = mv;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = ma[i];
            bus.req_b[i*W +: W] = mb[i];
            bus.req_cin[i]      = mc[i];
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (mv[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return 0;
    endfunction

    // One full transaction from grant to handshake; hold = cycles rsp_ready stays low.
    task automatic serve(input int hold, output int gs);
        logic [W:0] exp;
        apply();
        #1;
        gs  = pick();
        exp = (W+1)'(ma[gs]) + (W+1)'(mb[gs]) + (W+1)'(mc[gs]);
        chk("grant", 32'(bus.req_ready), 32'(1 << gs));
        chk("busy_idle", 32'(busy), 0);
        @(posedge clk); #1;
        mv[gs] = 1'b0;
        apply();
        chk("ready_issue", 32'(bus.req_ready), 0);
        chk("busy_issue", 32'(busy), 1);
        chk("add_a", 32'(add_a), 32'(ma[gs]));
        chk("add_b", 32'(add_b), 32'(mb[gs]));
        chk("add_cin", 32'(add_cin), 32'(mc[gs]));
        for (int s = 1; s < SETTLE; s++) begin
            @(posedge clk); #1;
            chk("early_valid", 32'(bus.rsp_valid), 0);
        end
        @(posedge clk); #1;
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", 32'(bus.rsp_valid), 1);
            chk("rsp_id", 32'(bus.rsp_id), 32'(gs));
            chk("rsp_sum", 32'(bus.rsp_sum), 32'(exp[W-1:0]));
            chk("rsp_cout", 32'(bus.rsp_cout), 32'(exp[W]));
`ifdef ALU_ARB_OVF_EN
            chk("rsp_ovf", 32'(bus.rsp_ovf),
                32'((ma[gs][W-1] == mb[gs][W-1]) && (exp[W-1] != ma[gs][W-1])));
`endif
            chk("ready_resp", 32'(bus.req_ready), 0);
            chk("busy_resp", 32'(busy), 1);
            if (h < hold) begin
                @(posedge clk); #1;
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        m_ptr = (gs + 1) % N;
        chk("valid_clr", 32'(bus.rsp_valid), 0);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        ma[i] = a; mb[i] = b; mc[i] = c; mv[i] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ma[i] = '0; mb[i] = '0; mc[i] = 1'b0;
        end
        mv = '0; m_ptr = 0;
        bus.rsp_ready = 1'b0;
        apply();
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_sum", 32'(bus.rsp_sum), 0);
        chk("rst_id", 32'(bus.rsp_id), 0);
        rst = 1'b0;

        set_req(0, 8'h01, 8'h01, 1'b0); serve(0, g);
        set_req(2, 8'hFF, 8'h01, 1'b0); serve(0, g);
        chk("id_req2", 32'(g), 2);
        set_req(1, 8'hFF, 8'hFF, 1'b0); serve(0, g);
        set_req(3, 8'h10, 8'h20, 1'b0); serve(0, g);

        // operands stay parked on the adder while idle
        repeat (2) @(posedge clk);
        #1;
        chk("idle_hold_a", 32'(add_a), 32'h10);

        set_req(0, 8'h01, 8'h01, 1'b1);
        set_req(1, 8'h02, 8'h03, 1'b0);
        set_req(2, 8'h41, 8'h81, 1'b0);
        set_req(3, 8'h19, 8'h31, 1'b0);
        for (int i = 0; i < 5; i++) begin
            serve(0, g);
            chk("rotate", 32'(g), 32'(i % N));
            mv[g] = 1'b1;
        end
        serve(5, g);
        mv = '0;
        set_req(g, 8'h33, 8'h44, 1'b1); serve(0, g);
        chk("regrant", 32'(g), 32'(g));
        set_req(g, 8'h05, 8'h06, 1'b0); serve(0, g);

        // reset lands mid-ISSUE: transaction is dropped and pointer restarts at 0
        mv = '0;
        set_req(2, 8'hAA, 8'h11, 1'b0);
        m_ptr = 3;
        serve_drop: begin
            apply(); #1;
            chk("grant_pre_rst", 32'(bus.req_ready), 32'b0100);
            @(posedge clk); #1;
            mv = '0; apply();
            rst = 1'b1; #1;
            chk("rst_mid_valid", 32'(bus.rsp_valid), 0);
            chk("rst_mid_busy", 32'(busy), 0);
            chk("rst_mid_add_a", 32'(add_a), 0);
            @(negedge clk);
            rst = 1'b0;
            m_ptr = 0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                chk("no_rsp_after_rst", 32'(bus.rsp_valid), 0);
            end
        end
        set_req(0, 8'h12, 8'h34, 1'b0);
        set_req(3, 8'h56, 8'h78, 1'b1);
        serve(0, g);
        chk("ptr_after_rst", 32'(g), 0);
        mv = '0;

`ifdef ALU_ARB_OVF_EN
        set_req(0, 8'h7F, 8'h01, 1'b0); serve(0, g);
        set_req(0, 8'h80, 8'h80, 1'b0); serve(0, g);
        set_req(0, 8'h01, 8'h01, 1'b0); serve(0, g);
`endif

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!mv[i] && ($urandom_range(0, 1) == 1))
                    set_req(i, W'($urandom), W'($urandom), 1'($urandom));
                else if (mv[i] && ($urandom_range(0, 3) == 0))
                    mv[i] = 1'b0;
            end
            if (mv == '0) set_req($urandom_range(0, N-1), W'($urandom), W'($urandom), 1'($urandom));
            serve($urandom_range(0, 3), g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_adder_arbiter.md
Name: alu_adder_arbiter

Overview:
- Shares the single 8-bit ripple-carry adder datapath (`ripplemod`) between NUM_REQ independent requesters.
- Round-robin arbitration, one transaction in flight at a time.
- Drives the adder's operand and carry-in ports from registers and waits a fixed settle time.
- Captures sum/carry-out and returns them with the requester ID over a valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- WIDTH, 8, operand width; matches adder width.
- ID_W, $clog2(NUM_REQ), width of the requester ID.
- SETTLE_CYCLES, 1, cycles operands are held on the adder before sampling; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept pulse.
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing.
- req_cin  in  NUM_REQ  carry-in per requester.
- add_a  out  WIDTH  to adder a.
- add_b  out  WIDTH  to adder b.
- add_cin  out  1  to adder cin.
- add_sum  in  WIDTH  from adder sum.
- add_cout  in  1  from adder cout.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of requester served.
- rsp_sum  out  WIDTH  captured sum.
- rsp_cout  out  1  captured carry-out.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, settle counter=0, req_ready=0, add_a/add_b/add_cin=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0.
- FSM states IDLE, ISSUE, RESP, encoded in the package.
- IDLE:
  - If any req_valid, pick the first set bit at or after rr_ptr, wrapping.
  - Assert req_ready[g] combinationally this cycle only.
  - Register req_a/req_b/req_cin of g into add_a/add_b/add_cin and g into rsp_id.
  - Load settle counter with SETTLE_CYCLES-1; go ISSUE.
  - No valid: stay in IDLE, req_ready=0.
- ISSUE: operands held stable. When counter==0, register add_sum→rsp_sum and add_cout→rsp_cout, set rsp_valid=1, go RESP. Otherwise decrement.
- RESP:
  - rsp_valid and all rsp_* held stable until rsp_valid&&rsp_ready.
  - On that cycle: rsp_valid←0, rr_ptr←(rsp_id+1) mod NUM_REQ, go IDLE.
  - No arbitration occurs in RESP.
- Latency: accept at cycle T → rsp_valid high from T+SETTLE_CYCLES+1. Peak throughput is one op per SETTLE_CYCLES+2 cycles with rsp_ready tied high.
- Arithmetic: {rsp_cout,rsp_sum} = a+b+cin, computed by the external adder. This block never adds.
- Boundaries:
  - Requester drops req_valid before grant: no grant, no error.
  - Requester must hold valid and data stable until req_ready.
  - All requesters valid continuously: grants rotate 0,1,2,3,0…
  - Only the just-served requester valid: it is re-granted (pointer wraps to it).
  - rr_ptr wraps NUM_REQ-1→0.
  - add_* keep last operands while in IDLE (no toggling).
  - Reset mid-ISSUE or mid-RESP: transaction dropped silently, no response.
  - Granted requester never sees a second req_ready for the same transaction.

Optional Feature:
- Macro ALU_ARB_OVF_EN.
- Defined:
  - Extra output port rsp_ovf (1 bit), registered with rsp_sum: signed overflow = (add_a[W-1]==add_b[W-1]) && (add_sum[W-1]!=add_a[W-1]).
  - Reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package alu_arb_pkg:
  - State encoding localparams/typedef (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2).
  - Default WIDTH=8.
  - Default NUM_REQ=4.
- Sub-module rr_arbiter: inputs req vector and rr_ptr; outputs one-hot grant and encoded index. Purely combinational mask-and-priority logic.
- FSM, counter and registers live in alu_adder_arbiter.
- Bench instantiates `ripplemod` on the add_* ports.

Test Plan:
- Req0 only, a=01 b=01 cin=0, rsp_ready=1 → req_ready[0] one pulse, rsp_sum=02, rsp_cout=0, rsp_id=0 at T+2 (SETTLE_CYCLES=1).
- Req2 only, a=FF b=01 cin=0 → rsp_sum=00, rsp_cout=1, rsp_id=2; req1 a=FF b=FF cin=0 → rsp_sum=FE, rsp_cout=1.
- All four valid continuously with distinct operands (e.g. 01+01+1, 02+03, 41+81, 19+31) → grant order 0,1,2,3, results 03/0, 05/0, C2/0, 4A/0.
- rsp_ready low for 5 cycles in RESP → rsp_valid and rsp_sum stable, req_ready stays 0, busy=1; grant resumes only after the handshake.
- rst asserted in ISSUE → all outputs 0 immediately, no rsp_valid; next request served from rr_ptr=0.
- ALU_ARB_OVF_EN defined: 7F+01 cin=0 → rsp_sum=80, rsp_ovf=1; 80+80 → rsp_sum=00, rsp_cout=1, rsp_ovf=1; 01+01 → rsp_ovf=0.
